// File: rtl/edu_tpu_pkg.sv
// Shared edu_tpu constants and the result collector state encoding.
package edu_tpu_pkg;
  localparam int ARRAY_SIZE     = 3;
  localparam int OUT_W          = 16;
  localparam int NUM_RESULTS    = ARRAY_SIZE * ARRAY_SIZE;
  localparam int NUM_WORDS      = (NUM_RESULTS + 1) / 2;
  localparam int COLLECT_CYCLES = 2 * ARRAY_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;
endpackage

// File: rtl/sysa_result_packer.sv
// Packs buffer entries {2k+1, 2k} into one 32-bit word; the odd tail is zero-padded.
module sysa_result_packer #(
  parameter int NRES  = 9,
  parameter int OUT_W = 16,
  parameter int KW    = 3
) (
  input  logic [NRES*OUT_W-1:0] i_buf,
  input  logic [KW-1:0]         i_k,
  output logic [31:0]           o_word
);
  localparam int NWORDS = (NRES + 1) / 2;

  logic [31:0] w_words [NWORDS];

  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    if (2*w + 1 < NRES) begin : g_pair
      assign w_words[w] = {i_buf[(2*w+1)*OUT_W +: OUT_W], i_buf[2*w*OUT_W +: OUT_W]};
    end else begin : g_tail
      assign w_words[w] = {{(32-OUT_W){1'b0}}, i_buf[2*w*OUT_W +: OUT_W]};
    end
  end

  // Indices past the last word select zero.
  always_comb begin
    o_word = '0;
    for (int w = 0; w < NWORDS; w++)
      if (i_k == KW'(w)) o_word = w_words[w];
  end
endmodule

// File: rtl/sysa_result_collector.sv
// De-skews systolic array column outputs into an NxN buffer and drains it as 32-bit words.
// Optional: define COLLECTOR_RELU_EN to clamp negative results to 0 at capture.
module sysa_result_collector #(
  parameter int ARRAY_SIZE = edu_tpu_pkg::ARRAY_SIZE,
  parameter int OUT_W      = edu_tpu_pkg::OUT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [ARRAY_SIZE*OUT_W-1:0] col_in,
  output logic [31:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
);
  import edu_tpu_pkg::state_e;
  import edu_tpu_pkg::IDLE;
  import edu_tpu_pkg::COLLECT;
  import edu_tpu_pkg::DRAIN;

  localparam int N      = ARRAY_SIZE;
  localparam int NRES   = N * N;
  localparam int NWORDS = (NRES + 1) / 2;
  localparam int NCYC   = 2 * N - 1;
  localparam int CW     = $clog2(NCYC + 1);
  localparam int KW     = $clog2(NWORDS + 1);

  state_e                    r_state, w_next;
  logic [CW-1:0]             r_cyc;
  logic [KW-1:0]             r_word, w_pack_k;
  logic [NRES*OUT_W-1:0]     r_buf;
  logic [31:0]               r_out_data, w_packed;
  logic                      r_out_valid, r_out_last;
  logic                      w_capture, w_final, w_hs, w_last_hs;
  logic [N-1:0][OUT_W-1:0]   w_col_val;

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [OUT_W-1:0] w_raw;
    assign w_raw = col_in[c*OUT_W +: OUT_W];
`ifdef COLLECTOR_RELU_EN
    assign w_col_val[c] = w_raw[OUT_W-1] ? '0 : w_raw;
`else
    assign w_col_val[c] = w_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)     w_next = COLLECT;
      COLLECT: if (w_final)   w_next = DRAIN;
      DRAIN:   if (w_last_hs) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    w_capture = (r_state == COLLECT) && in_valid;
    w_final   = w_capture && (r_cyc == CW'(NCYC - 1));
    w_hs      = (r_state == DRAIN) && r_out_valid && out_ready;
    w_last_hs = w_hs && (r_word == KW'(NWORDS - 1));
    // Word 0 is loaded on the DRAIN entry edge; later words are prefetched on each handshake.
    w_pack_k  = (r_state == DRAIN) ? r_word + 1'b1 : '0;
  end

  sysa_result_packer #(
    .NRES  (NRES),
    .OUT_W (OUT_W),
    .KW    (KW)
  ) u_packer (
    .i_buf  (r_buf),
    .i_k    (w_pack_k),
    .o_word (w_packed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc       <= '0;
      r_word      <= '0;
      r_buf       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (r_state == IDLE && start) r_cyc <= '0;
      // Column c sees its row r result on valid cycle c+r (array output skew).
      if (w_capture) begin
        r_cyc <= r_cyc + 1'b1;
        for (int c = 0; c < N; c++)
          for (int r = 0; r < N; r++)
            if (r_cyc == CW'(c + r)) r_buf[(c*N + r)*OUT_W +: OUT_W] <= w_col_val[c];
      end
      if (w_final) begin
        r_word      <= '0;
        r_out_data  <= w_packed;
        r_out_valid <= 1'b1;
        r_out_last  <= (NWORDS == 1);
      end else if (w_last_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_hs) begin
        r_word      <= r_word + 1'b1;
        r_out_data  <= w_packed;
        r_out_last  <= (r_word == KW'(NWORDS - 2));
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
endmodule

// File: tb/tb_sysa_result_collector.sv
// Scoreboard bench for sysa_result_collector: stimulus pushes expected words, a monitor pops on handshake.
module tb_sysa_result_collector;
  import edu_tpu_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst, start, in_valid, out_ready;
  logic [ARRAY_SIZE*OUT_W-1:0] col_in;
  logic [31:0]                 out_data;
  logic                        out_valid, out_last, busy;

  int total = 0;
  int bad   = 0;

  logic [OUT_W-1:0] vals [NUM_RESULTS];
  logic [31:0]      expw [NUM_WORDS];
  logic [32:0]      sbq  [$];

  always #5 clk = ~clk;

  sysa_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .col_in    (col_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [15:0] ev(logic [15:0] v);
`ifdef COLLECTOR_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted word is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_word", {out_last, out_data}, 33'h0);
      else                 chk("drain_word", {out_last, out_data}, sbq.pop_front());
    end
  end

  task automatic push_expected();
    logic [15:0] lo, hi;
    for (int w = 0; w < NUM_WORDS; w++) begin
      lo = ev(vals[2*w]);
      hi = 16'h0000;
      if (2*w + 1 < NUM_RESULTS) hi = ev(vals[2*w+1]);
      expw[w] = {hi, lo};
      sbq.push_back({(w == NUM_WORDS-1), hi, lo});
    end
  endtask

  // Runs one collection; returns one #1 after the edge that enters DRAIN.
  task automatic collect(bit stall, bit start_mid);
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < COLLECT_CYCLES; t++) begin
      if (t == COLLECT_CYCLES-1) chk("pre_drain_valid", {32'h0, out_valid}, 33'h0);
      in_valid = 1'b1;
      start    = start_mid && (t == 2);
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        col_in[c*OUT_W +: OUT_W] = 16'hBEEF;
        if (t >= c && t < c + ARRAY_SIZE) col_in[c*OUT_W +: OUT_W] = vals[c*ARRAY_SIZE + t - c];
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (stall && t != COLLECT_CYCLES-1) begin
        in_valid = 1'b0;
        col_in   = {ARRAY_SIZE{16'h5A5A}};
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("drain_entry", {31'h0, out_valid, busy}, 33'h3);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid) break;
    end
    chk("drain_complete", 33'(sbq.size()), 33'h0);
    chk("busy_after_drain", {31'h0, out_valid, busy}, 33'h0);
    sbq.delete();
  endtask

  task automatic load_base();
    for (int c = 0; c < ARRAY_SIZE; c++)
      for (int r = 0; r < ARRAY_SIZE; r++)
        vals[c*ARRAY_SIZE + r] = 16'(16'h10 * c + r + 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0; col_in = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("reset_state", {out_data, out_valid}, 33'h0);
    chk("reset_flags", {31'h0, out_last, busy}, 33'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_no_effect", {31'h0, out_valid, busy}, 33'h0);

    // Basic collect; hand table: words 00020001 00110003 00130012 00220021 00000023.
    load_base();
    collect(1'b0, 1'b0);
    chk("word0_hand", {1'b0, out_data}, {1'b0, 32'h0002_0001});
    wait_done();
    chk("tail_hand", {1'b0, expw[4]}, {1'b0, 32'h0000_0023});

    // Stall every other cycle.
    collect(1'b1, 1'b0);
    wait_done();

    // Backpressure on word 2.
    collect(1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, out_data}, {1'b1, 32'h0013_0012});
    end
    out_ready = 1'b1;
    wait_done();

    // Start pulses in COLLECT and DRAIN are ignored.
    collect(1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    @(posedge clk); #1;
    chk("no_restart", {31'h0, out_valid, busy}, 33'h0);

    // Reset mid-DRAIN after word 1 is accepted.
    collect(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == NUM_WORDS - 2) break;
      @(negedge clk);
    end
    chk("rst_wait", 33'(sbq.size()), 33'(NUM_WORDS - 2));
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_drain", {30'h0, out_valid, busy, out_last}, 33'h0);
    chk("rst_data", {1'b0, out_data}, 33'h0);
    out_ready = 1'b1;
    for (int i = 0; i < NUM_RESULTS; i++) vals[i] = 16'(16'h0100 + 3 * i);
    collect(1'b0, 1'b0);
    wait_done();

    // Sign handling: clamped to 0 with the ReLU build, raw otherwise.
    load_base();
    vals[0] = 16'hFFFE; vals[1] = 16'h7FFF; vals[2] = 16'h8000; vals[8] = 16'h8000;
    collect(1'b0, 1'b0);
`ifdef COLLECTOR_RELU_EN
    chk("relu_word0", {1'b0, out_data}, {1'b0, 32'h7FFF_0000});
`else
    chk("raw_word0", {1'b0, out_data}, {1'b0, 32'h7FFF_FFFE});
`endif
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
